pc_gen: RTL

//  Parametrised program-counter generator for the pipelined CPU front end; successor to the fixed 32-bit PC.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_pend_latch.sv | 41 ++++
 rtl/pc_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program-counter generator.
// Pending-event kinds are ordered so an exception is never displaced by a later redirect.
package pc_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam int          STEP_DEF      = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0040;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    REDIR,
    EXC
  } pend_kind_e;

endpackage

// File: rtl/pc_pend_latch.sv
// Holds one redirect/exception that arrived while the PC was held; 1-cycle capture, cleared on apply.
// Exception overwrites anything pending; a redirect only overwrites a pending redirect.
module pc_pend_latch
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_capture,
  input  logic            i_clear,
  input  logic            i_exc,
  input  logic            i_redir,
  input  logic [XLEN-1:0] i_target,
  output pend_kind_e      o_kind,
  output logic [XLEN-1:0] o_target
);

  pend_kind_e      r_kind;
  logic [XLEN-1:0] r_target;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kind   <= NONE;
      r_target <= '0;
    end else if (i_clear) begin
      r_kind <= NONE;
    end else if (i_capture) begin
      if (i_exc) begin
        r_kind <= EXC;
      end else if (i_redir && (r_kind != EXC)) begin
        r_kind   <= REDIR;
        r_target <= i_target;
      end
    end
  end

  assign o_kind   = r_kind;
  assign o_target = r_target;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: advances by STEP per unheld cycle, redirect/exception applied after one edge.
// Events arriving while held are latched and applied on the first unheld cycle.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              STEP      = STEP_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_hazard_i,
  input  logic            stall_mem_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            exc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            pend_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_misalign;
  logic            w_hold;
  logic            w_run;
  logic            w_misalign;
  logic            w_exc_evt;
  logic            w_redir_evt;
  pend_kind_e      w_pend_kind;
  logic [XLEN-1:0] w_pend_target;

  assign w_hold      = ~start_i | stall_hazard_i | stall_mem_i;
  assign w_run       = (r_state == RUN);
  // Mask is zero for STEP=1, so no redirect is ever misaligned there.
  assign w_misalign  = redirect_valid_i && ((redirect_target_i & ALIGN_MASK) != '0);
  assign w_exc_evt   = exc_i | w_misalign;
  assign w_redir_evt = redirect_valid_i & ~w_misalign;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && start_i) w_state_nxt = RUN;
  end

  always_comb begin
    pc_valid_o = w_run & ~w_hold;
  end

  pc_pend_latch #(
    .XLEN (XLEN)
  ) u_pend (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_capture (w_run & w_hold),
    .i_clear   (w_run & ~w_hold),
    .i_exc     (w_exc_evt),
    .i_redir   (w_redir_evt),
    .i_target  (redirect_target_i),
    .o_kind    (w_pend_kind),
    .o_target  (w_pend_target)
  );

  // Live events beat the pending one; exceptions beat redirects.
  always_comb begin
    w_pc_nxt = r_pc + XLEN'(STEP);
    if (w_exc_evt)                w_pc_nxt = EXC_VEC;
    else if (w_redir_evt)         w_pc_nxt = redirect_target_i;
    else if (w_pend_kind == EXC)  w_pc_nxt = EXC_VEC;
    else if (w_pend_kind == REDIR) w_pc_nxt = w_pend_target;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_run & w_misalign;
      if (w_run && !w_hold) r_pc <= w_pc_nxt;
    end
  end

  assign pc_o       = r_pc;
  assign pend_o     = (w_pend_kind != NONE);
  assign misalign_o = r_misalign;

endmodule
